board_checker: RTL and testbench
================================

# board_checker

Player-side counterpart to the board generator. It latches the 12-bit board produced by the generator, collects the player's guess one 3-bit cell at a time from one-cycle button flags, and compares the guess with the latched board. It reports per-attempt match counts and a final win/lose verdict. It runs on the divided game clock and consumes the debounced pulse flags from the button flag blocks.

## Interface
- MAX_TRY, 3: attempts allowed per round, 1..7.
- clk  input  1  divided game clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- board  input  12  generated board; cell i = board[3i+2:3i], i = 0..3.
- val  input  3  cell value currently on switches.
- start_flag  input  1  one-cycle pulse; starts a new round.
- cf_flag  input  1  one-cycle pulse; confirms val into the current cell.
- bk_flag  input  1  one-cycle pulse; steps back one cell.
- answer  output  12  guess being assembled, same cell packing as board.
- idx  output  3  next cell to fill, 0..4.
- hits  output  3  cells matching in the last checked attempt, 0..4.
- tries  output  3  attempts consumed this round.
- busy  output  1  high in ENTER or CHECK.
- win  output  1  high in WIN.
- lose  output  1  high in LOSE.

## Operation
- States: IDLE, ENTER, CHECK, WIN, LOSE. Reset state is IDLE.
- start_flag in any state:
  - latch board into brd_q;
  - clear answer, idx, hits and tries;
  - go to ENTER.
- start_flag has priority over cf_flag and bk_flag in the same cycle.
- ENTER, cf_flag with idx < 4: write val into answer cell idx, then idx += 1.
- ENTER, cf_flag when idx == 4: go to CHECK; answer and idx are unchanged.
- ENTER, bk_flag with no cf_flag and idx > 0: idx -= 1 and clear answer cell idx-1. bk_flag with idx == 0 is ignored.
- cf_flag and bk_flag in the same cycle: cf_flag acts, bk_flag is ignored.
- CHECK lasts exactly one cycle:
  - hits is the number of cells i with answer cell == brd_q cell;
  - tries += 1.
- CHECK exit, evaluated with the updated tries:
  - hits == 4 -> WIN;
  - else tries == MAX_TRY -> LOSE;
  - else -> ENTER with answer cleared and idx = 0.
- WIN and LOSE hold until start_flag or rst. cf_flag and bk_flag are ignored there and in IDLE.
- Changes on the board input after the latch are ignored until the next start_flag.
- Arithmetic:
  - hits is a 3-bit sum of four 1-bit compares;
  - tries saturates at MAX_TRY and never wraps.

## Timing
- Reset values: answer = 0, idx = 0, hits = 0, tries = 0, busy = 0, win = 0, lose = 0.
- rst asserted mid-round aborts it immediately and asynchronously; all outputs take their reset values.
- All outputs are registered or decoded from state. No combinational path from any input to any output.
- start_flag at edge N: busy = 1 and idx = 0 after edge N.
- Each cf_flag updates answer and idx on the same edge.
- Fifth cf_flag, with idx == 4, at edge N:
  - state = CHECK after edge N;
  - hits and tries update at edge N+1;
  - win, lose, or the ENTER return are visible after edge N+1.
- hits holds its last value through the next ENTER phase until the next CHECK or start_flag.
- Flags are assumed to be single-cycle. A flag held high acts once per cycle.

## Test plan
- Reset, then start_flag with board = 12'o7531. Enter 1,3,5,7 (cell 0 first), then cf_flag -> answer = 12'o7531, hits = 4, tries = 1, win = 1, busy = 0.
- MAX_TRY = 3, board = 12'o0000. Three attempts of 1,1,1,1 -> hits = 0 after each attempt; tries counts 1, 2, 3; lose = 1 after the third CHECK; a further cf_flag leaves everything unchanged.
- Enter 2,2 then bk_flag -> idx = 1, answer cell 1 = 0. A bk_flag at idx = 0 has no effect. cf_flag and bk_flag in the same cycle with val = 6 -> the cell is written and idx increments.
- Partial match, board = 12'o4321, guess 1,2,0,0 -> hits = 2, tries = 1; state returns to ENTER with answer = 0 and idx = 0.
- Change board to 12'o7777 mid-round. The guess matching the original latched board still gives hits = 4 and win = 1.
- Assert rst asynchronously between clock edges during ENTER with idx = 3 -> all outputs go to 0 immediately. start_flag and cf_flag in the same cycle -> restart only, idx = 0.

Source files
------------

// File: rtl/board_checker.sv
// Player-side guess checker: latches the generated board, collects a 4-cell guess
// from one-cycle button flags, scores it and reports win/lose.
module board_checker #(
  parameter int unsigned MAX_TRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] board,
  input  logic [2:0]  val,
  input  logic        start_flag,
  input  logic        cf_flag,
  input  logic        bk_flag,
  output logic [11:0] answer,
  output logic [2:0]  idx,
  output logic [2:0]  hits,
  output logic [2:0]  tries,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  localparam int unsigned CELLS = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned BW    = CELLS * CW;

  typedef enum logic [2:0] {IDLE, ENTER, CHECK, WIN, LOSE} state_t;

  state_t        state;
  logic [BW-1:0] brd_q;
  logic [2:0]    match_cnt;
  logic [2:0]    tries_inc;

  // Per-cell compare of the assembled guess against the latched board.
  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < CELLS; i++) begin
      match_cnt = match_cnt + 3'(answer[i*CW +: CW] == brd_q[i*CW +: CW]);
    end
  end

  assign tries_inc = (tries < 3'(MAX_TRY)) ? tries + 3'd1 : tries;

  assign busy = (state == ENTER) || (state == CHECK);
  assign win  = (state == WIN);
  assign lose = (state == LOSE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      brd_q  <= '0;
      answer <= '0;
      idx    <= '0;
      hits   <= '0;
      tries  <= '0;
    end else if (start_flag) begin
      state  <= ENTER;
      brd_q  <= board;
      answer <= '0;
      idx    <= '0;
      hits   <= '0;
      tries  <= '0;
    end else begin
      case (state)
        ENTER: begin
          if (cf_flag) begin
            if (idx == 3'(CELLS)) begin
              state <= CHECK;
            end else begin
              for (int i = 0; i < CELLS; i++) begin
                if (3'(i) == idx) answer[i*CW +: CW] <= val;
              end
              idx <= idx + 3'd1;
            end
          end else if (bk_flag && (idx != 3'd0)) begin
            // Step back and clear the cell being abandoned.
            for (int i = 0; i < CELLS; i++) begin
              if (3'(i + 1) == idx) answer[i*CW +: CW] <= '0;
            end
            idx <= idx - 3'd1;
          end
        end
        CHECK: begin
          hits  <= match_cnt;
          tries <= tries_inc;
          if (match_cnt == 3'(CELLS)) begin
            state <= WIN;
          end else if (tries_inc == 3'(MAX_TRY)) begin
            state <= LOSE;
          end else begin
            state  <= ENTER;
            answer <= '0;
            idx    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_checker.sv
// Self-checking bench for board_checker: directed scenarios plus randomized
// flag traffic, all compared against a cell-array reference model.
module tb_board_checker;

  localparam int unsigned MAX_TRY = 3;
  localparam int P_IDLE = 0, P_ENTER = 1, P_CHECK = 2, P_WIN = 3, P_LOSE = 4;

  logic        clk;
  logic        rst;
  logic [11:0] board;
  logic [2:0]  val;
  logic        start_flag, cf_flag, bk_flag;
  logic [11:0] answer;
  logic [2:0]  idx, hits, tries;
  logic        busy, win, lose;

  board_checker #(.MAX_TRY(MAX_TRY)) dut (
    .clk(clk), .rst(rst), .board(board), .val(val),
    .start_flag(start_flag), .cf_flag(cf_flag), .bk_flag(bk_flag),
    .answer(answer), .idx(idx), .hits(hits), .tries(tries),
    .busy(busy), .win(win), .lose(lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the game as lists of cell values and counters.
  int m_phase;
  int m_cells [4];
  int m_brd   [4];
  int m_n, m_hits, m_tries;

  function automatic void model_reset();
    m_phase = P_IDLE; m_n = 0; m_hits = 0; m_tries = 0;
    for (int i = 0; i < 4; i++) begin m_cells[i] = 0; m_brd[i] = 0; end
  endfunction

  function automatic void model_step(input bit s, input bit c, input bit b,
                                     input int v, input logic [11:0] bd);
    int h;
    if (s) begin
      for (int i = 0; i < 4; i++) begin
        m_brd[i] = int'((bd >> (3 * i)) & 12'h7);
        m_cells[i] = 0;
      end
      m_n = 0; m_hits = 0; m_tries = 0; m_phase = P_ENTER;
    end else if (m_phase == P_ENTER) begin
      if (c) begin
        if (m_n < 4) begin m_cells[m_n] = v; m_n++; end
        else m_phase = P_CHECK;
      end else if (b && m_n > 0) begin
        m_n--; m_cells[m_n] = 0;
      end
    end else if (m_phase == P_CHECK) begin
      h = 0;
      for (int i = 0; i < 4; i++) if (m_cells[i] == m_brd[i]) h++;
      m_hits = h;
      if (m_tries < int'(MAX_TRY)) m_tries++;
      if (h == 4) m_phase = P_WIN;
      else if (m_tries == int'(MAX_TRY)) m_phase = P_LOSE;
      else begin
        m_phase = P_ENTER; m_n = 0;
        for (int i = 0; i < 4; i++) m_cells[i] = 0;
      end
    end
  endfunction

  function automatic logic [11:0] model_answer();
    logic [11:0] a = '0;
    for (int i = 0; i < 4; i++) a = a | (12'(m_cells[i]) << (3 * i));
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("answer", 32'(answer), 32'(model_answer()));
    chk("idx",    32'(idx),    32'(m_n));
    chk("hits",   32'(hits),   32'(m_hits));
    chk("tries",  32'(tries),  32'(m_tries));
    chk("busy",   32'(busy),   32'(m_phase == P_ENTER || m_phase == P_CHECK));
    chk("win",    32'(win),    32'(m_phase == P_WIN));
    chk("lose",   32'(lose),   32'(m_phase == P_LOSE));
  endtask

  task automatic step(input bit s, input bit c, input bit b,
                      input logic [2:0] v, input logic [11:0] bd);
    @(negedge clk);
    start_flag = s; cf_flag = c; bk_flag = b; val = v; board = bd;
    @(posedge clk);
    model_step(s, c, b, int'(v), bd);
    #1 check_all();
  endtask

  task automatic enter4(input logic [2:0] a0, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] a3);
    step(0, 1, 0, a0, board);
    step(0, 1, 0, a1, board);
    step(0, 1, 0, a2, board);
    step(0, 1, 0, a3, board);
  endtask

  initial begin
    logic [2:0] v;
    rst = 1'b1; board = '0; val = '0;
    start_flag = 0; cf_flag = 0; bk_flag = 0;
    model_reset();
    #12 check_all();
    @(negedge clk) rst = 1'b0;

    // Full match on the first attempt.
    step(1, 0, 0, 3'd0, 12'o7531);
    chk("start_busy", 32'(busy), 32'd1);
    enter4(3'd1, 3'd3, 3'd5, 3'd7);
    chk("answer_7531", 32'(answer), 32'o7531);
    step(0, 1, 0, 3'd0, board);
    step(0, 0, 0, 3'd0, board);
    chk("win_hits", 32'(hits), 32'd4);
    chk("win_flag", 32'(win), 32'd1);
    chk("win_tries", 32'(tries), 32'd1);

    // Three misses exhaust the attempts.
    step(1, 0, 0, 3'd0, 12'o0000);
    for (int t = 1; t <= 3; t++) begin
      enter4(3'd1, 3'd1, 3'd1, 3'd1);
      step(0, 1, 0, 3'd0, board);
      step(0, 0, 0, 3'd0, board);
      chk("lose_tries", 32'(tries), 32'(t));
    end
    chk("lose_flag", 32'(lose), 32'd1);
    step(0, 1, 1, 3'd5, board);
    chk("lose_hold_tries", 32'(tries), 32'd3);

    // Back-step behaviour and cf/bk collision.
    step(1, 0, 0, 3'd0, 12'o1234);
    step(0, 1, 0, 3'd2, board);
    step(0, 1, 0, 3'd2, board);
    step(0, 0, 1, 3'd0, board);
    chk("bk_idx", 32'(idx), 32'd1);
    chk("bk_answer", 32'(answer), 32'o0002);
    step(0, 0, 1, 3'd0, board);
    step(0, 0, 1, 3'd0, board);
    chk("bk_at_zero", 32'(idx), 32'd0);
    step(0, 1, 1, 3'd6, board);
    chk("cf_bk_answer", 32'(answer), 32'o0006);

    // Partial match returns to entry.
    step(1, 0, 0, 3'd0, 12'o4321);
    enter4(3'd1, 3'd2, 3'd0, 3'd0);
    step(0, 1, 0, 3'd0, board);
    step(0, 0, 0, 3'd0, board);
    chk("partial_hits", 32'(hits), 32'd2);
    chk("partial_idx", 32'(idx), 32'd0);

    // Board changes after the latch are ignored.
    step(1, 0, 0, 3'd0, 12'o2604);
    board = 12'o7777;
    enter4(3'd4, 3'd0, 3'd6, 3'd2);
    step(0, 1, 0, 3'd0, 12'o7777);
    step(0, 0, 0, 3'd0, 12'o7777);
    chk("latched_win", 32'(win), 32'd1);

    // Asynchronous reset mid-entry, then start+cf collision.
    step(1, 0, 0, 3'd0, 12'o1111);
    step(0, 1, 0, 3'd3, board);
    step(0, 1, 0, 3'd3, board);
    step(0, 1, 0, 3'd3, board);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;
    step(1, 1, 0, 3'd5, 12'o1111);
    chk("start_cf_idx", 32'(idx), 32'd0);

    // Randomized flag traffic, biased toward correct cells to reach wins.
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 1) == 1 && m_n < 4) ? 3'(m_brd[m_n]) : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) == 0), v,
           ($urandom_range(0, 9) == 0) ? 12'($urandom) : board);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
